seq_control_unit: RTL
=====================

# seq_control_unit

Multi-cycle, parametrised instruction controller for the micro-CPU; successor to the single-cycle combinational decoder. It sits between instruction fetch and the register file/ALU datapath. It accepts one instruction at a time over a valid/ready handshake and latches it. It then sequences execute and write-back with registered control outputs, supporting multi-cycle MUL, a zero-flag conditional jump and a halt state.

## Interface
Parameters:
- INSTR_W, 16, instruction width; must be ≥ OPC_W + 3*REG_AW
- OPC_W, 4, opcode width (opcode = instr[INSTR_W-1 -: OPC_W])
- REG_AW, 4, register-address width
- MUL_CYCLES, 3, EXEC cycles for MUL (≥1)
- PC_W (localparam) = INSTR_W − OPC_W, jump-target width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- instr_valid  in  1  fetch presents an instruction
- instr  in  INSTR_W  instruction word
- instr_ready  out  1  controller can accept; transfer = valid && ready
- alu_zero  in  1  ALU zero result, sampled in WB
- alu_op  out  OPC_W  ALU operation code
- alu_src1 / alu_src2 / alu_dest  out  REG_AW each  fields [INSTR_W-OPC_W-1 -: REG_AW], next REG_AW down, next REG_AW down
- reg_write_enable  out  1  register-file write strobe
- load_pc  out  1  PC load strobe
- load_pc_val  out  PC_W  jump target = instr[PC_W-1:0]
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  controller in HALTED

## Operation
- Opcodes: NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5, JMP 6, JZ 7, HALT all-ones. Every other opcode is illegal.
- States: IDLE, EXEC, WB, HALTED.
- IDLE:
  - instr_ready=1.
  - On transfer: latch instr into IR, clear the MUL counter, go to EXEC.
- EXEC:
  - ALU ops: drive alu_op=opcode and the src1/src2/dest fields from IR.
  - ADD/SUB/AND/OR go to WB after 1 cycle. MUL stays for MUL_CYCLES cycles (counter 0..MUL_CYCLES−1), then goes to WB.
  - JMP: load_pc=1 and load_pc_val=IR[PC_W-1:0] for one cycle, then IDLE.
  - JZ: the same as JMP only if z_flag=1. Otherwise load_pc=0. Either way, then IDLE.
  - NOP: no strobes, back to IDLE.
  - Illegal opcode: illegal_op=1 for one cycle, treated as NOP.
  - HALT: go to HALTED.
- WB:
  - ALU fields are held; reg_write_enable=1 for exactly one cycle.
  - z_flag ← alu_zero.
  - Then go to IDLE.
- HALTED: instr_ready=0 and halted=1 until rst.
- Outside EXEC/WB, alu_op, alu_src1, alu_src2, alu_dest, load_pc_val and the strobes are all 0. No output depends combinationally on instr.
- z_flag updates only in WB. JZ tests the result of the most recent ALU write-back, and z_flag is unaffected by NOP, JMP or JZ.

## Timing
- Reset values (the cycle after rst is sampled high):
  - State IDLE; IR, z_flag and the counter are 0.
  - instr_ready=1; every other output is 0.
  - While rst is high, instr_valid is ignored.
- Transfer at edge T:
  - EXEC occupies cycle T+1.
  - For ALU ops, the WB strobe is in cycle T+2. For MUL it is in cycle T+1+MUL_CYCLES.
  - instr_ready returns to 1 the cycle after the last EXEC or WB cycle.
- Throughput:
  - ALU op: one instruction per 3 cycles.
  - MUL: one per MUL_CYCLES+2 cycles.
  - JMP/JZ/NOP: one per 2 cycles.
- instr_ready is 0 in EXEC, WB and HALTED. The fetch stage must hold instr stable until transfer; instr is not sampled at any other time.
- Reset mid-operation (EXEC, WB, mid-MUL or HALTED): abort. No reg_write_enable or load_pc is issued after rst is sampled high.
- load_pc and reg_write_enable are never both 1 in the same cycle.

## Configuration
- Macro: SEQ_CU_COND_BRANCH_EN.
- Defined: JZ is decoded as above, and z_flag is implemented.
- Undefined: opcode 7 is illegal (illegal_op pulse, NOP behaviour), and there is no z_flag register.

## Test plan
- Reset, then transfer ADD 0x1234 at edge T. Require alu_op=1, src1=2, src2=3, dest=4 in T+1 and T+2. Require reg_write_enable=1 only in T+2 and instr_ready=1 again in T+3.
- With MUL_CYCLES=3, transfer MUL 0x3567. Require alu_op=3 for T+1..T+4, reg_write_enable only in T+4, and instr_ready=0 throughout T+1..T+4.
- Transfer JMP 0x6ABC. Require load_pc=1 with load_pc_val=0xABC in T+1 only, and reg_write_enable=0 throughout.
- Run SUB with alu_zero=1 in WB, then JZ 0x7010. Require load_pc=1 with target 0x010. Repeat with alu_zero=0: require load_pc=0. With the macro undefined, require illegal_op=1 instead.
- Transfer opcode 0x8 (illegal): require an illegal_op pulse in T+1 and no strobes. Transfer HALT 0xF000: require halted=1 and instr_ready=0 until rst, with instr_valid ignored.
- Assert rst in the second EXEC cycle of a MUL. Require no reg_write_enable, and require all outputs at reset values the next cycle.

Source files
------------

// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: IDLE -> EXEC (-> WB) -> IDLE, plus a sticky HALTED state.
// Define SEQ_CU_COND_BRANCH_EN to decode JZ (opcode 7) and keep a zero flag from ALU write-back.
module seq_control_unit #(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned MUL_CYCLES = 3,
    localparam int unsigned PC_W      = INSTR_W - OPC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               alu_zero,
    output logic [OPC_W-1:0]   alu_op,
    output logic [REG_AW-1:0]  alu_src1,
    output logic [REG_AW-1:0]  alu_src2,
    output logic [REG_AW-1:0]  alu_dest,
    output logic               reg_write_enable,
    output logic               load_pc,
    output logic [PC_W-1:0]    load_pc_val,
    output logic               illegal_op,
    output logic               halted
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_WB     = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(6);
`ifdef SEQ_CU_COND_BRANCH_EN
    localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(7);
`endif
    localparam logic [OPC_W-1:0] OP_HALT = {OPC_W{1'b1}};

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        logic ok;
        ok = is_alu(op) || (op == OP_NOP) || (op == OP_JMP) || (op == OP_HALT);
`ifdef SEQ_CU_COND_BRANCH_EN
        ok = ok || (op == OP_JZ);
`endif
        return ok;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPC_W-1:0]   opc_q, opc_d;

`ifdef SEQ_CU_COND_BRANCH_EN
    logic z_flag_q, z_flag_d;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

    logic              ready_q, ready_d;
    logic [OPC_W-1:0]  alu_op_q, alu_op_d;
    logic [REG_AW-1:0] src1_q, src1_d;
    logic [REG_AW-1:0] src2_q, src2_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              rwe_q, rwe_d;
    logic              lpc_q, lpc_d;
    logic [PC_W-1:0]   lpc_val_q, lpc_val_d;
    logic              ill_q, ill_d;
    logic              halted_q, halted_d;

    assign opc_q = ir_q[INSTR_W-1 -: OPC_W];
    assign opc_d = ir_d[INSTR_W-1 -: OPC_W];

    // Sequencing: IR is only written on a handshake in IDLE.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef SEQ_CU_COND_BRANCH_EN
        z_flag_d = z_flag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && ready_q) begin
                    ir_d    = instr;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opc_q == OP_HALT) begin
                    state_d = ST_HALTED;
                end else if (opc_q == OP_MUL) begin
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_d = ST_WB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (is_alu(opc_q)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
`ifdef SEQ_CU_COND_BRANCH_EN
                z_flag_d = alu_zero;
`endif
                state_d = ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every control output leaves a flop.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        halted_d  = (state_d == ST_HALTED);
        alu_op_d  = '0;
        src1_d    = '0;
        src2_d    = '0;
        dest_d    = '0;
        rwe_d     = 1'b0;
        lpc_d     = 1'b0;
        lpc_val_d = '0;
        ill_d     = 1'b0;
        if ((state_d == ST_EXEC || state_d == ST_WB) && is_alu(opc_d)) begin
            alu_op_d = opc_d;
            src1_d   = ir_d[INSTR_W-OPC_W-1 -: REG_AW];
            src2_d   = ir_d[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
            dest_d   = ir_d[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
        end
        if (state_d == ST_WB) begin
            rwe_d = 1'b1;
        end
        if (state_d == ST_EXEC) begin
            if (opc_d == OP_JMP) begin
                lpc_d     = 1'b1;
                lpc_val_d = ir_d[PC_W-1:0];
            end
`ifdef SEQ_CU_COND_BRANCH_EN
            if (opc_d == OP_JZ && z_flag_d) begin
                lpc_d     = 1'b1;
                lpc_val_d = ir_d[PC_W-1:0];
            end
`endif
            ill_d = !is_legal(opc_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            halted_q  <= 1'b0;
            alu_op_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            rwe_q     <= 1'b0;
            lpc_q     <= 1'b0;
            lpc_val_q <= '0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            halted_q  <= halted_d;
            alu_op_q  <= alu_op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dest_q    <= dest_d;
            rwe_q     <= rwe_d;
            lpc_q     <= lpc_d;
            lpc_val_q <= lpc_val_d;
            ill_q     <= ill_d;
        end
    end

`ifdef SEQ_CU_COND_BRANCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            z_flag_q <= 1'b0;
        end else begin
            z_flag_q <= z_flag_d;
        end
    end
`endif

    assign instr_ready      = ready_q;
    assign halted           = halted_q;
    assign alu_op           = alu_op_q;
    assign alu_src1         = src1_q;
    assign alu_src2         = src2_q;
    assign alu_dest         = dest_q;
    assign reg_write_enable = rwe_q;
    assign load_pc          = lpc_q;
    assign load_pc_val      = lpc_val_q;
    assign illegal_op       = ill_q;

endmodule
